// File: rtl/uart_rx_capture.sv
// ============================================================================
// uart_rx_capture : programmable-rate serial receiver with FWFT receive FIFO
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_capture #(
    parameter int DIV_W      = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_frame_err,
    output logic                          rd_parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          busy
);

    localparam int                   c_addr_w    = $clog2(FIFO_DEPTH);
    localparam int                   c_word_w    = DATA_BITS + 2;
    localparam logic [3:0]           c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0]           c_last_stop = 4'(STOP_BITS - 1);
    localparam logic [DIV_W-1:0]     c_min_div   = DIV_W'(4);
    localparam logic [DIV_W-1:0]     c_one       = DIV_W'(1);
    localparam logic                 c_odd       = (PARITY == 1);
    localparam logic [c_addr_w:0]    c_depth     = (c_addr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_prev;
    logic [DIV_W-1:0]       r_div_q;
    logic [DIV_W-1:0]       r_cnt;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_frame_err;

    logic                   w_start_edge;
    logic                   w_sample;
    logic                   w_push;
    logic                   w_par_bad;
    logic [DIV_W-1:0]       w_div_eff;
    logic [c_word_w-1:0]    w_push_word;

    logic [c_word_w-1:0]    r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0]    r_wptr;
    logic [c_addr_w-1:0]    r_rptr;
    logic [c_addr_w:0]      r_count;
    logic                   r_overrun;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic                   w_ovr_set;
    logic [c_word_w-1:0]    w_head;

    // Synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_start_edge = ~r_sync2 & r_prev;
    assign w_sample     = (r_cnt == '0);
    assign w_div_eff    = (cfg_div < c_min_div) ? c_min_div : cfg_div;
    assign w_par_bad    = ((^r_shift) ^ r_sync2) != c_odd;
    assign w_push_word  = {r_frame_err | ~r_sync2, r_par_err, r_shift};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_sample) begin
                    w_state_next = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_sample && (r_bit_cnt == c_last_data)) begin
                    w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (w_sample) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_sample && (r_bit_cnt == c_last_stop)) begin
                    w_state_next = S_IDLE;
                    w_push       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit timing and frame assembly; the period is frozen per frame in r_div_q
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div_q     <= '0;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start_edge) begin
                r_div_q     <= w_div_eff;
                r_cnt       <= (w_div_eff >> 1) - c_one;
                r_bit_cnt   <= '0;
                r_par_err   <= 1'b0;
                r_frame_err <= 1'b0;
            end
        end else begin
            r_cnt <= w_sample ? (r_div_q - c_one) : (r_cnt - c_one);
            if (w_sample) begin
                r_bit_cnt <= (w_state_next != r_state) ? 4'd0 : (r_bit_cnt + 4'd1);
                case (r_state)
                    S_DATA:  r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
                    S_PAR:   r_par_err <= w_par_bad;
                    S_STOP: begin
                        if (!r_sync2) begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_pop     = rd_en & ~w_empty;
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + {{c_addr_w{1'b0}}, w_wr} - {{c_addr_w{1'b0}}, w_pop};
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Head is masked while empty so stale storage never reaches the outputs
    assign w_head        = r_mem[r_rptr];
    assign rd_valid      = ~w_empty;
    assign rd_data       = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign rd_parity_err = ~w_empty & w_head[c_word_w-2];
    assign rd_frame_err  = ~w_empty & w_head[c_word_w-1];
    assign fifo_count    = r_count;
    assign overrun       = r_overrun;
    assign busy          = (r_state != S_IDLE);

endmodule

`default_nettype wire
